icache_ctrl: RTL
================

# icache_ctrl

Direct-mapped instruction cache and line-fill controller sitting directly upstream of instruction fetch: converts the fetch stage's word-address read request into a single-cycle instruction on a hit, and runs a multi-beat line fill from backing instruction memory on a miss. Fetch stalls while `instr_vld` is low.

## Interface
Parameters:
- `INDEX_BITS`, default 3: line index width (2^INDEX_BITS lines).
- `OFFSET_BITS`, default 2: word-in-line width (2^OFFSET_BITS 16-bit words per line).

Ports:
- `clk`  in  1  — single clock; all state updates on posedge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `rd_en`  in  1  — fetch request valid this cycle.
- `addr`  in  16  — word address (pc) of requested instruction.
- `inv`  in  1  — invalidate all lines.
- `instr`  out  16  — instruction word; 0 when `instr_vld`=0.
- `instr_vld`  out  1  — `instr` valid for `addr` this cycle.
- `mem_re`  out  1  — backing-memory read request.
- `mem_addr`  out  16  — backing-memory word address.
- `mem_rdy`  in  1  — `mem_data` valid; completes current beat.
- `mem_data`  in  16  — backing-memory read data.
- `hit_cnt`, `miss_cnt`  out  16 each — present only with `ICACHE_STATS_EN`.

## Operation
- Address split: offset = `addr[OFFSET_BITS-1:0]`, index = next INDEX_BITS bits, tag = remaining upper bits.
- Storage: per-line valid bit, tag, 2^OFFSET_BITS data words.
- Hit = `rd_en` & state IDLE & valid[index] & tag match. Combinational: `instr_vld`=1, `instr`=data word, same cycle.
- FSM states: IDLE, FILL.
- IDLE, `rd_en` & miss & !`inv`: latch line base {tag,index,0}, beat count=0, valid[index] cleared, go FILL at edge.
- FILL: `mem_re`=1, `mem_addr`=base+count, held stable until `mem_rdy`. On `mem_rdy`: write `mem_data` to word count, count++. On last beat: write tag, set valid, go IDLE.
- FILL ignores `addr`/`rd_en` changes (redirect mid-fill): fill completes for latched line; new address evaluated in IDLE.
- `inv` in IDLE: all valid bits cleared at edge; a hit in that same cycle still reported.
- `inv` in FILL: fill aborted, valid bits cleared, go IDLE at edge; `mem_re` low next cycle; line stays invalid. Backing memory tolerates request withdrawal.
- `mem_rdy` in IDLE: ignored.
- `instr_vld`=0 throughout FILL.

## Timing
- Reset (async): state IDLE, all valid=0, `mem_re`=0, `mem_addr`=0, `instr_vld`=0, `instr`=0, counters=0. Reset mid-fill abandons fill immediately.
- Hit latency: 0 cycles (combinational from `addr`).
- Miss detected cycle T; `mem_re` first asserted T+1. With zero-wait memory (`mem_rdy` same cycle as `mem_re`), beats at T+1..T+4, hit at T+5 (default OFFSET_BITS). With W wait cycles per beat: hit at T+1+4(W+1).
- One beat per cycle maximum; `mem_addr` changes only on the edge after `mem_rdy`.

## Configuration
- `ICACHE_STATS_EN` defined: `hit_cnt` increments each cycle a hit occurs; `miss_cnt` increments on each IDLE→FILL transition; both saturate at 0xFFFF, reset to 0, unaffected by `inv`.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Cold miss: reset, `rd_en`=1 `addr`=0x0000, zero-wait memory returning `addr`^0xA5A5 -> `mem_addr` 0x0000..0x0003 on cycles 1-4, `instr_vld`=1 `instr`=0xA5A5 cycle 5; then 0x0001..0x0003 hit same cycle with 0xA5A4, 0xA5A7, 0xA5A6.
- Conflict eviction: after line 0x0000 filled, fetch 0x0020 (index 0, tag 1) -> miss, fill 0x0020..0x0023; refetch 0x0000 -> miss again.
- Wait states: `mem_rdy` 2 cycles after each `mem_re` beat (W=2) -> `mem_addr` stable across waits, hit at T+13.
- Invalidate: `inv` in IDLE after fill -> next 0x0000 fetch misses. `inv` during FILL after beat 2 -> `mem_re`=0 next cycle, refetch performs full 4-beat fill.
- Redirect mid-fill: `addr` 0x0000 miss, switch to 0x0004 at beat 1 -> fill of 0x0000..0x0003 completes, then 0x0004 misses and fills.
- Stats (`ICACHE_STATS_EN`): cold-miss scenario -> `miss_cnt`=1, `hit_cnt`=4; forced 0xFFFF+ hits -> `hit_cnt` holds 0xFFFF.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a multi-beat line-fill controller.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic [15:0] addr,
    input  logic        inv,
    output logic [15:0] instr,
    output logic        instr_vld,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [15:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = 16 - INDEX_BITS - OFFSET_BITS;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, nextState;

    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tags [LINES];
    logic [15:0]            data [LINES][WORDS];

    logic [TAG_BITS-1:0]    fillTag;
    logic [INDEX_BITS-1:0]  fillIdx;
    logic [OFFSET_BITS-1:0] beatCnt;

    logic [OFFSET_BITS-1:0] addrOff;
    logic [INDEX_BITS-1:0]  addrIdx;
    logic [TAG_BITS-1:0]    addrTag;
    logic hit, lastBeat, startFill, beatDone;

    assign addrOff = addr[OFFSET_BITS-1:0];
    assign addrIdx = addr[OFFSET_BITS +: INDEX_BITS];
    assign addrTag = addr[15 -: TAG_BITS];

    assign hit       = rd_en && (state == IDLE) && valid[addrIdx] && (tags[addrIdx] == addrTag);
    assign instr_vld = hit;
    assign instr     = hit ? data[addrIdx][addrOff] : 16'h0000;

    assign mem_re   = (state == FILL);
    assign mem_addr = mem_re ? {fillTag, fillIdx, beatCnt} : 16'h0000;
    assign lastBeat = (beatCnt == OFFSET_BITS'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        startFill = 1'b0;
        beatDone  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !hit && !inv) begin
                    startFill = 1'b1;
                    nextState = FILL;
                end
            end
            FILL: begin
                // Invalidate wins over a beat arriving in the same cycle.
                if (inv) begin
                    nextState = IDLE;
                end else if (mem_rdy) begin
                    beatDone = 1'b1;
                    if (lastBeat) nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            fillTag <= '0;
            fillIdx <= '0;
            beatCnt <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (startFill) begin
            valid[addrIdx] <= 1'b0;
            fillTag        <= addrTag;
            fillIdx        <= addrIdx;
            beatCnt        <= '0;
        end else if (beatDone) begin
            beatCnt <= beatCnt + OFFSET_BITS'(1);
            if (lastBeat) valid[fillIdx] <= 1'b1;
        end
    end

    // Line storage needs no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (beatDone) begin
            data[fillIdx][beatCnt] <= mem_data;
            if (lastBeat) tags[fillIdx] <= fillTag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (hit && hit_cnt != 16'hFFFF)        hit_cnt  <= hit_cnt + 16'd1;
            if (startFill && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif

endmodule
